// File: rtl/time_pkg.sv
// Shared types and constants for the time-of-day setter.
package time_pkg;
  typedef enum logic [2:0] {RUN, EDIT_HOUR, EDIT_MIN, EDIT_SEC, COMMIT} state_t;

  localparam logic [1:0] FIELD_HOUR = 2'd0;
  localparam logic [1:0] FIELD_MIN  = 2'd1;
  localparam logic [1:0] FIELD_SEC  = 2'd2;
  localparam logic [1:0] FIELD_NONE = 2'd3;

  localparam int SEC_W  = 6;
  localparam int MIN_W  = 6;
  localparam int HOUR_W = 5;

  localparam logic [SEC_W-1:0]  SEC_MAX  = 6'd59;
  localparam logic [MIN_W-1:0]  MIN_MAX  = 6'd59;
  localparam logic [HOUR_W-1:0] HOUR_MAX = 5'd23;

  // Field code shown on the field output for a given state.
  function automatic logic [1:0] field_of(input state_t s);
    case (s)
      EDIT_HOUR: field_of = FIELD_HOUR;
      EDIT_MIN:  field_of = FIELD_MIN;
      EDIT_SEC:  field_of = FIELD_SEC;
      default:   field_of = FIELD_NONE;
    endcase
  endfunction

  function automatic logic is_edit(input state_t s);
    is_edit = (s == EDIT_HOUR) || (s == EDIT_MIN) || (s == EDIT_SEC);
  endfunction
endpackage

// File: rtl/btn_pulse.sv
// Rising-edge detector for one button; with TIME_SETTER_AUTOREPEAT_EN it
// also emits auto-repeat steps while the button stays held.
module btn_pulse #(
  parameter bit RPT          = 1'b0,
  parameter int REPEAT_DELAY = 50,
  parameter int REPEAT_PERIOD = 10
) (
  input  logic clk,
  input  logic reset,
  input  logic level,
  input  logic clr,      // abort any repeat (state change pending/occurred)
  input  logic inhibit,  // both up and down held
  output logic evt,
  output logic step
);
  logic prev;

  // Previous level resets high so a button held through reset is not an event.
  always_ff @(posedge clk) begin
    if (!reset) prev <= 1'b1;
    else        prev <= level;
  end

  assign evt = level & ~prev;

`ifdef TIME_SETTER_AUTOREPEAT_EN
  localparam int MAXC = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int CW = $clog2(MAXC + 1);

  logic [CW-1:0] cnt;
  logic          active, first, hold, rpt;
  logic [CW-1:0] tgt;

  assign hold = RPT && active && level && !inhibit && !clr;
  assign tgt  = first ? CW'(REPEAT_DELAY) : CW'(REPEAT_PERIOD);
  assign rpt  = hold && (cnt == tgt);

  // cnt holds cycles since the event or the last repeat step.
  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt    <= '0;
      active <= 1'b0;
      first  <= 1'b0;
    end else if (RPT && evt && !clr) begin
      cnt    <= CW'(1);
      active <= 1'b1;
      first  <= 1'b1;
    end else if (!hold) begin
      active <= 1'b0;
    end else if (rpt) begin
      cnt   <= CW'(1);
      first <= 1'b0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  assign step = evt | rpt;
`else
  logic unused_cfg;
  assign unused_cfg = clr ^ inhibit ^ RPT ^ REPEAT_DELAY[0] ^ REPEAT_PERIOD[0];
  assign step = evt;
`endif
endmodule

// File: rtl/time_setter.sv
// Button-driven hour/minute/second editor feeding a time counter's set port.
// Optional auto-repeat on held up/down: define TIME_SETTER_AUTOREPEAT_EN.
module time_setter
  import time_pkg::*;
#(
  parameter int TIMEOUT       = 1000,
  parameter int REPEAT_DELAY  = 50,
  parameter int REPEAT_PERIOD = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              btn_mode,
  input  logic              btn_up,
  input  logic              btn_down,
  input  logic [SEC_W-1:0]  cur_sec,
  input  logic [MIN_W-1:0]  cur_min,
  input  logic [HOUR_W-1:0] cur_hour,
  output logic              set,
  output logic [SEC_W-1:0]  sec_set,
  output logic [MIN_W-1:0]  min_set,
  output logic [HOUR_W-1:0] hour_set,
  output logic              editing,
  output logic [1:0]        field
);
  localparam int TW = $clog2(TIMEOUT + 1);

  state_t        state, nstate;
  logic [TW-1:0] tmo_cnt;
  logic          mode_evt, up_evt, down_evt;
  logic          mode_step, up_step, down_step;
  logic          rpt_clr, both_held, act, tmo_hit;
  logic          load, inc, dec;

  assign both_held = btn_up & btn_down;
  assign rpt_clr   = mode_step | ~is_edit(state);

  btn_pulse #(.RPT(1'b0), .REPEAT_DELAY(REPEAT_DELAY), .REPEAT_PERIOD(REPEAT_PERIOD)) u_mode (
    .clk(clk), .reset(reset), .level(btn_mode), .clr(1'b0), .inhibit(1'b0),
    .evt(mode_evt), .step(mode_step));
  btn_pulse #(.RPT(1'b1), .REPEAT_DELAY(REPEAT_DELAY), .REPEAT_PERIOD(REPEAT_PERIOD)) u_up (
    .clk(clk), .reset(reset), .level(btn_up), .clr(rpt_clr), .inhibit(both_held),
    .evt(up_evt), .step(up_step));
  btn_pulse #(.RPT(1'b1), .REPEAT_DELAY(REPEAT_DELAY), .REPEAT_PERIOD(REPEAT_PERIOD)) u_down (
    .clk(clk), .reset(reset), .level(btn_down), .clr(rpt_clr), .inhibit(both_held),
    .evt(down_evt), .step(down_step));

  logic unused_evt;
  assign unused_evt = mode_evt ^ up_evt ^ down_evt;

  assign act     = mode_step | up_step | down_step;
  assign tmo_hit = (tmo_cnt == TW'(TIMEOUT - 1));

  // Next-state and field-step decode; mode wins, up+down cancel.
  always_comb begin
    nstate = state;
    load   = 1'b0;
    inc    = 1'b0;
    dec    = 1'b0;
    case (state)
      RUN: if (mode_step) begin
        nstate = EDIT_HOUR;
        load   = 1'b1;
      end
      EDIT_HOUR, EDIT_MIN, EDIT_SEC: begin
        if (mode_step) begin
          nstate = (state == EDIT_HOUR) ? EDIT_MIN :
                   (state == EDIT_MIN)  ? EDIT_SEC : COMMIT;
        end else if (act) begin
          inc = up_step & ~down_step;
          dec = down_step & ~up_step;
        end else if (tmo_hit) begin
          nstate = RUN;
        end
      end
      COMMIT:  nstate = RUN;
      default: nstate = RUN;
    endcase
  end

  // State, idle counter and registered status outputs.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state   <= RUN;
      tmo_cnt <= '0;
      set     <= 1'b0;
      editing <= 1'b0;
      field   <= FIELD_NONE;
    end else begin
      state   <= nstate;
      set     <= (nstate == COMMIT);
      editing <= is_edit(nstate);
      field   <= field_of(nstate);
      if (nstate != state || act || !is_edit(state)) tmo_cnt <= '0;
      else                                           tmo_cnt <= tmo_cnt + TW'(1);
    end
  end

  // Edit registers: seeded on entry, stepped with wrap in the active field only.
  always_ff @(posedge clk) begin
    if (!reset) begin
      hour_set <= '0;
      min_set  <= '0;
      sec_set  <= '0;
    end else if (load) begin
      hour_set <= (cur_hour > HOUR_MAX) ? '0 : cur_hour;
      min_set  <= (cur_min  > MIN_MAX)  ? '0 : cur_min;
      sec_set  <= (cur_sec  > SEC_MAX)  ? '0 : cur_sec;
    end else if (inc) begin
      case (state)
        EDIT_HOUR: hour_set <= (hour_set == HOUR_MAX) ? '0 : hour_set + HOUR_W'(1);
        EDIT_MIN:  min_set  <= (min_set  == MIN_MAX)  ? '0 : min_set + MIN_W'(1);
        EDIT_SEC:  sec_set  <= (sec_set  == SEC_MAX)  ? '0 : sec_set + SEC_W'(1);
        default: ;
      endcase
    end else if (dec) begin
      case (state)
        EDIT_HOUR: hour_set <= (hour_set == '0) ? HOUR_MAX : hour_set - HOUR_W'(1);
        EDIT_MIN:  min_set  <= (min_set  == '0) ? MIN_MAX  : min_set - MIN_W'(1);
        EDIT_SEC:  sec_set  <= (sec_set  == '0) ? SEC_MAX  : sec_set - SEC_W'(1);
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_time_setter.sv
// Directed bench for time_setter: reset, edit/commit, sanitising, wrap,
// timeout, mid-edit reset and held-button stepping.
module tb_time_setter;
  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       btn_mode = 1'b0, btn_up = 1'b0, btn_down = 1'b0;
  logic [5:0] cur_sec = '0, cur_min = '0;
  logic [4:0] cur_hour = '0;
  logic       set, editing;
  logic [5:0] sec_set, min_set;
  logic [4:0] hour_set;
  logic [1:0] field;

  int checks = 0;
  int failures = 0;
  int set_pulses = 0;

`ifdef TIME_SETTER_AUTOREPEAT_EN
  localparam int EXP_RPT = 4;
`else
  localparam int EXP_RPT = 1;
`endif

  time_setter #(.TIMEOUT(20), .REPEAT_DELAY(4), .REPEAT_PERIOD(2)) dut (
    .clk(clk), .reset(reset), .btn_mode(btn_mode), .btn_up(btn_up), .btn_down(btn_down),
    .cur_sec(cur_sec), .cur_min(cur_min), .cur_hour(cur_hour),
    .set(set), .sec_set(sec_set), .min_set(min_set), .hour_set(hour_set),
    .editing(editing), .field(field));

  always #5 clk = ~clk;

  always @(posedge clk) #1 if (set === 1'b1) set_pulses++;

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic press_mode();
    btn_mode = 1'b1; tick();
  endtask

  task automatic release_all();
    btn_mode = 1'b0; btn_up = 1'b0; btn_down = 1'b0; tick();
  endtask

  initial begin
    cur_hour = 5'd12; cur_min = 6'd34; cur_sec = 6'd56;
    btn_mode = 1'b1;
    tick(2);
    chk("rst_set", set, 0);
    chk("rst_editing", editing, 0);
    chk("rst_field", field, 3);
    chk("rst_hour", hour_set, 0);
    chk("rst_sec", sec_set, 0);
    reset = 1'b1;
    tick(2);
    chk("held_mode_no_evt", editing, 0);
    release_all();
    press_mode();
    chk("enter_editing", editing, 1);
    chk("enter_field", field, 0);
    chk("seed_hour", hour_set, 12);
    release_all();
    btn_down = 1'b1; tick();
    chk("hour_dec1", hour_set, 11);
    release_all();
    btn_down = 1'b1; tick();
    chk("hour_dec2", hour_set, 10);
    release_all();
    press_mode();
    chk("field_min", field, 1);
    release_all();
    btn_up = 1'b1; tick();
    chk("min_inc", min_set, 35);
    release_all();
    press_mode();
    chk("field_sec", field, 2);
    release_all();
    press_mode();
    chk("commit_set", set, 1);
    chk("commit_field", field, 3);
    chk("commit_hour", hour_set, 10);
    chk("commit_min", min_set, 35);
    chk("commit_sec", sec_set, 56);
    btn_mode = 1'b0; tick();
    chk("post_set", set, 0);
    chk("post_editing", editing, 0);
    chk("post_hold_min", min_set, 35);

    cur_hour = 5'd27; cur_min = 6'd61; cur_sec = 6'd5;
    press_mode();
    chk("san_hour", hour_set, 0);
    chk("san_min", min_set, 0);
    chk("san_sec", sec_set, 5);
    release_all();
    btn_down = 1'b1; tick();
    chk("hour_wrap_dn", hour_set, 23);
    release_all();
    btn_up = 1'b1; tick();
    chk("hour_wrap_up", hour_set, 0);
    release_all();
    press_mode();
    release_all();
    btn_down = 1'b1; tick();
    chk("min_wrap_dn", min_set, 59);
    release_all();
    btn_up = 1'b1; btn_down = 1'b1; tick();
    chk("updn_cancel", min_set, 59);
    chk("updn_no_sec", sec_set, 5);
    release_all();
    tick(18);
    chk("tmo_not_yet", editing, 1);
    tick();
    chk("tmo_editing", editing, 0);
    chk("tmo_field", field, 3);
    chk("tmo_hold_min", min_set, 59);
    chk("tmo_no_set", set_pulses, 1);

    cur_hour = 5'd12; cur_min = 6'd34; cur_sec = 6'd56;
    press_mode();
    release_all();
    chk("mid_editing", editing, 1);
    reset = 1'b0; tick();
    chk("mid_rst_editing", editing, 0);
    chk("mid_rst_field", field, 3);
    chk("mid_rst_hour", hour_set, 0);
    chk("mid_rst_min", min_set, 0);
    chk("mid_rst_sec", sec_set, 0);
    chk("mid_rst_set", set, 0);
    reset = 1'b1; tick();

    cur_hour = 5'd0; cur_min = 6'd0; cur_sec = 6'd0;
    press_mode(); release_all();
    press_mode(); release_all();
    press_mode(); release_all();
    chk("rpt_field", field, 2);
    btn_up = 1'b1; tick(10);
    btn_up = 1'b0; tick();
    chk("rpt_sec", sec_set, EXP_RPT);
    chk("total_sets", set_pulses, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/time_setter.md
# time_setter

Button-driven editor that produces the load side of the time-of-day counter's set interface. It watches three user buttons, walks an hour → minute → second edit sequence seeded from the running time, and issues a single-cycle `set` strobe with range-checked values on commit. It sits between the board button inputs and the time counter: its `set`/`*_set` outputs drive the counter's set/value inputs, and the counter's outputs feed back into `cur_*`.

## Interface
- `TIMEOUT`, 1000: idle cycles in any edit state before the edit is aborted without commit; must be ≥ 1.
- `REPEAT_DELAY`, 50: cycles a held up/down button must stay high before the first auto-repeat step; only used with `TIME_SETTER_AUTOREPEAT_EN`.
- `REPEAT_PERIOD`, 10: cycles between later auto-repeat steps; only used with `TIME_SETTER_AUTOREPEAT_EN`.
- `clk` in 1: single clock; all logic on posedge.
- `reset` in 1: synchronous, active-low. Low at a posedge resets the block.
- `btn_mode`, `btn_up`, `btn_down` in 1 each: button levels, already synchronised and debounced.
- `cur_sec` in 6, `cur_min` in 6, `cur_hour` in 5: current time from the counter.
- `set` out 1: one-cycle commit strobe.
- `sec_set` out 6, `min_set` out 6, `hour_set` out 5: edit registers, driven directly.
- `editing` out 1: high in any edit state.
- `field` out 2: field being edited: 0 hour, 1 minute, 2 second, 3 idle/commit.

## Operation
- Every button has a previous-level register. An event is a sampled level of 1 with a previous level of 0.
- Previous-level registers reset to 1, so a button held through reset creates no event until it is released and pressed again.
- States and transitions:
  - RUN → EDIT_HOUR on a mode event. On entry, load `hour_set`/`min_set`/`sec_set` from `cur_*`. Any out-of-range value (hour ≥ 24, min/sec ≥ 60) loads as 0.
  - EDIT_HOUR → EDIT_MIN on a mode event.
  - EDIT_MIN → EDIT_SEC on a mode event.
  - EDIT_SEC → COMMIT on a mode event.
  - COMMIT → RUN unconditionally after one cycle.
- In an edit state, an up event increments the active field and a down event decrements it, with wrap-around:
  - hour: 23→0 and 0→23.
  - minute and second: 59→0 and 0→59.
- Arithmetic is done in field width. Wrap is detected by comparing against HOUR_MAX/MIN_MAX/SEC_MAX before adding, so no overflow bit is needed.
- Only the active field changes. No carry propagates between fields.
- Simultaneous events:
  - A mode event takes priority; up/down events in the same cycle are discarded.
  - Up and down events in the same cycle cancel each other (no change), but they still reload the timeout.
- Timeout:
  - A counter reloads on state entry and on every button event or repeat step.
  - If it reaches `TIMEOUT` idle cycles in any edit state, the next state is RUN, `set` is never asserted, and the edit registers hold their last values.
- Up/down events in RUN and COMMIT are ignored.
- Reset values: state RUN, `set`=0, `editing`=0, `field`=3, `sec_set`/`min_set`/`hour_set`=0, timeout and repeat counters=0.
- If reset is asserted mid-edit, all of the above apply at that posedge. No commit occurs.

## Timing
- All outputs are registered.
- Event at posedge N: the state change or field update is visible after posedge N (one-cycle latency from the first sampled high).
- `set` is high for exactly the one cycle the block is in COMMIT. `*_set` are stable for that whole cycle and stay unchanged afterwards until the next edit entry.
- `editing` and `field` change in the same cycle as the state.
- A button must be sampled low for at least one cycle between events.

## Configuration
- `TIME_SETTER_AUTOREPEAT_EN` defined:
  - An up or down level held continuously after its event produces extra steps at `REPEAT_DELAY` cycles after the event, then every `REPEAT_PERIOD` cycles.
  - Repeat stops when the level falls, when both buttons are high, or when the state changes.
  - Repeat steps reload the timeout.
- Undefined: only events step a field. Repeat counters and parameters are unused and synthesise away.

## Structure
- Package `time_pkg` holds:
  - state enum (RUN, EDIT_HOUR, EDIT_MIN, EDIT_SEC, COMMIT);
  - field codes (FIELD_HOUR=0, FIELD_MIN=1, FIELD_SEC=2, FIELD_NONE=3);
  - width constants SEC_W=6, MIN_W=6, HOUR_W=5;
  - limits SEC_MAX=59, MIN_MAX=59, HOUR_MAX=23.
- One sub-module, `btn_pulse`, is instantiated once per button. It contains the edge detector plus, under the macro, the repeat counter, and outputs a one-cycle step pulse.

## Test plan
- Release reset with `btn_mode` held high → no transition; release and press mode → `editing`=1, `field`=0 one cycle later.
- `cur`=12:34:56, mode, 2× down, mode, up, mode, mode → exactly one `set` pulse with 10:35:56.
- `cur_hour`=27, `cur_min`=61, `cur_sec`=5, enter edit → `hour_set`=0, `min_set`=0, `sec_set`=5.
- Wrap: hour 23 up → 0; minute 0 down → 59; up and down in the same cycle → no change.
- Enter edit, stay idle `TIMEOUT` cycles → back to RUN, `set` never asserted; reset low mid-edit → all outputs at reset values next cycle.
- With macro, `REPEAT_DELAY`=4, `REPEAT_PERIOD`=2, hold up 10 cycles in EDIT_SEC from 0 → `sec_set`=4; without macro → 1.
